layer_sequencer: RTL and testbench

- Top-level layer scheduler for the detection pipeline.
- Drives the 4-bit `state` bus consumed by the conv and avg-pool multi-core engines (e.g. Avg_Pool_Multiple_Cores), stepping CONV→AVG→FLUSH for three layers.
- Advances on engine `done` handshakes rather than fixed cycle counts.
- Also owns the ping-pong feature-map BRAM bank select and a per-frame cycle counter.

---
 rtl/layer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer scheduler: steps CONV -> AVG -> FLUSH for three layers on engine done handshakes,
// owns the ping-pong bank select and a frame cycle counter. Optional watchdog: SEQ_WATCHDOG_EN.
module layer_sequencer #(
    parameter int FLUSH_CYCLES   = 20,
    parameter int CYC_W          = 20,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             conv_done,
    input  logic             pool_done,
    output logic [3:0]       state,
    output logic             busy,
    output logic             frame_done,
    output logic             bank_sel,
    output logic [1:0]       layer_idx,
    output logic [CYC_W-1:0] cycle_count,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FINISHED = 4'd1,
        S_CONV1    = 4'd2,
        S_AVG1     = 4'd3,
        S_FLUSH1   = 4'd4,
        S_CONV2    = 4'd5,
        S_AVG2     = 4'd6,
        S_FLUSH2   = 4'd7,
        S_CONV3    = 4'd8,
        S_AVG3     = 4'd9,
        S_FLUSH3   = 4'd10
    } state_e;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CYC_W < 1) begin : g_bad_params
        $error("layer_sequencer: FLUSH_CYCLES, TIMEOUT_CYCLES and CYC_W must be >= 1");
    end

    state_e            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              bank_sel_q, bank_sel_d;
    logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              err_q, err_d;
`endif

    function automatic logic is_active(input state_e s);
        return !(s == S_IDLE || s == S_FINISHED);
    endfunction

    // The encoding is sequential inside a layer and between layers, so most
    // advances are state+1; only FLUSH3 jumps to FINISHED.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        bank_sel_d    = bank_sel_q;
        cycle_count_d = cycle_count_q;
`ifdef SEQ_WATCHDOG_EN
        err_d         = err_q;
`endif
        if (is_active(state_q) && cycle_count_q != {CYC_W{1'b1}}) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_FINISHED: begin
                if (start) begin
                    state_d       = S_CONV1;
                    bank_sel_d    = 1'b0;
                    cycle_count_d = '0;
`ifdef SEQ_WATCHDOG_EN
                    err_d         = 1'b0;
`endif
                end
            end
            S_CONV1, S_CONV2, S_CONV3: begin
                if (conv_done) begin
                    state_d    = state_e'(state_q + 4'd1);
                    bank_sel_d = ~bank_sel_q;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d = S_FINISHED;
                    err_d   = 1'b1;
                end
`endif
            end
            S_AVG1, S_AVG2, S_AVG3: begin
                if (pool_done) begin
                    state_d     = state_e'(state_q + 4'd1);
                    bank_sel_d  = ~bank_sel_q;
                    flush_cnt_d = FLUSH_LOAD;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d = S_FINISHED;
                    err_d   = 1'b1;
                end
`endif
            end
            S_FLUSH1, S_FLUSH2, S_FLUSH3: begin
                if (flush_cnt_q == '0) begin
                    state_d = (state_q == S_FLUSH3) ? S_FINISHED : state_e'(state_q + 4'd1);
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SEQ_WATCHDOG_EN
        // Any state change restarts the watchdog, which covers entry to every CONV/AVG.
        wd_cnt_d = (state_d != state_q) ? '0 : wd_cnt_q + 1'b1;
`endif
        busy_d       = is_active(state_d);
        frame_done_d = (state_d == S_FINISHED) && (state_q != S_FINISHED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            flush_cnt_q   <= '0;
            bank_sel_q    <= 1'b0;
            cycle_count_q <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt_q      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            bank_sel_q    <= bank_sel_d;
            cycle_count_q <= cycle_count_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            S_CONV1, S_AVG1, S_FLUSH1: layer_idx = 2'd0;
            S_CONV2, S_AVG2, S_FLUSH2: layer_idx = 2'd1;
            S_CONV3, S_AVG3, S_FLUSH3: layer_idx = 2'd2;
            default:                   layer_idx = 2'd3;
        endcase
    end

    assign state       = state_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign bank_sel    = bank_sel_q;
    assign cycle_count = cycle_count_q;
`ifdef SEQ_WATCHDOG_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: drivers push expected state transitions and
// frame results; a negedge monitor pops and compares whenever the DUT changes state.
module tb_layer_sequencer;
    localparam int FLUSH = 20;
    localparam int CYC_W = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             conv_done = 1'b0;
    logic             pool_done = 1'b0;
    logic [3:0]       state;
    logic             busy;
    logic             frame_done;
    logic             bank_sel;
    logic [1:0]       layer_idx;
    logic [CYC_W-1:0] cycle_count;
    logic             err;

    layer_sequencer #(
        .FLUSH_CYCLES(FLUSH),
        .CYC_W(CYC_W),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .conv_done(conv_done),
        .pool_done(pool_done),
        .state(state),
        .busy(busy),
        .frame_done(frame_done),
        .bank_sel(bank_sel),
        .layer_idx(layer_idx),
        .cycle_count(cycle_count),
        .err(err)
    );

    always #5 clk = ~clk;

    // Transition record: {state, bank_sel, busy, layer_idx}
    logic [7:0]       exp_q[$];
    logic [CYC_W-1:0] fd_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [CYC_W-1:0] cnt);
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back({4'(2 + 3 * n), 1'b0, 1'b1, 2'(n)});
            exp_q.push_back({4'(3 + 3 * n), 1'b1, 1'b1, 2'(n)});
            exp_q.push_back({4'(4 + 3 * n), 1'b0, 1'b1, 2'(n)});
        end
        exp_q.push_back({4'd1, 1'b0, 1'b0, 2'd3});
        fd_q.push_back(cnt);
    endtask

    task automatic wait_state(input logic [3:0] st);
        int t = 0;
        while (state !== st && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (state !== st) begin
            checks++;
            errors++;
            $display("FAIL wait_state: got %0d expected %0d", state, st);
        end
    endtask

    // Holds state st for k cycles; the real done (rc/rp) arrives on cycle k,
    // an optional spurious conv/pool/start pulse on cycle sa.
    task automatic step(input logic [3:0] st, input int k, input logic rc, input logic rp,
                        input int sa, input logic sc, input logic sp, input logic ss);
        wait_state(st);
        for (int i = 1; i <= k; i++) begin
            conv_done = (i == k) ? rc : ((i == sa) ? sc : 1'b0);
            pool_done = (i == k) ? rp : ((i == sa) ? sp : 1'b0);
            start     = (i == sa && i != k) ? ss : 1'b0;
            @(negedge clk);
        end
        conv_done = 1'b0;
        pool_done = 1'b0;
        start     = 1'b0;
    endtask

    task automatic start_frame(input logic [CYC_W-1:0] cnt);
        push_frame(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_cycle_count", cycle_count, 0);
        chk("start_err", err, 0);
    endtask

    task automatic run_frame(input int k);
        step(4'd2, k, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(4'd3, k, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(4'd5, k, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(4'd6, k, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(4'd8, k, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(4'd9, k, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        wait_state(4'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_bank_sel"}, bank_sel, 0);
        chk({tag, "_layer_idx"}, layer_idx, 3);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Monitor
    logic [3:0] prev_state = 4'd0;
    logic       prev_fd = 1'b0;
    int         dwell = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_state = 4'd0;
            prev_fd    = 1'b0;
            dwell      = 0;
        end else begin
            if (state !== prev_state) begin
                if (prev_state == 4'd4 || prev_state == 4'd7 || prev_state == 4'd10) begin
                    chk("flush_dwell", dwell, FLUSH);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition: got state %0d, none expected", state);
                end else begin
                    chk("transition", {state, bank_sel, busy, layer_idx}, exp_q.pop_front());
                end
                dwell = 1;
            end else begin
                dwell++;
            end
            if (frame_done) begin
                chk("frame_done_state", state, 1);
                chk("frame_done_width", prev_fd, 0);
                if (fd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got pulse, none expected");
                end else begin
                    chk("frame_cycle_count", cycle_count, fd_q.pop_front());
                end
            end
            prev_fd    = frame_done;
            prev_state = state;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Frame A: spurious dones and a start while busy, 10-cycle engine dwell
        start_frame(CYC_W'(6 * 10 + 3 * FLUSH));
        step(4'd2, 10, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        step(4'd3, 10, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        wait_state(4'd4);
        repeat (4) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        step(4'd5, 10, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        step(4'd6, 10, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(4'd8, 10, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1);
        step(4'd9, 10, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        wait_state(4'd1);
        repeat (5) @(negedge clk);
        chk("finished_hold_state", state, 1);
        chk("finished_bank_sel", bank_sel, 0);
        chk("finished_layer_idx", layer_idx, 3);
        chk("finished_count_frozen", cycle_count, 6 * 10 + 3 * FLUSH);

        // Frame B: restart from FINISHED, 7-cycle engine dwell
        start_frame(CYC_W'(6 * 7 + 3 * FLUSH));
        run_frame(7);
        @(negedge clk);

        // Frame C: abandoned by an asynchronous reset while in AVG2
        start_frame(CYC_W'(0));
        step(4'd2, 10, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(4'd3, 10, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(4'd5, 10, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        wait_state(4'd6);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        fd_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Frame D: clean frame after reset
        start_frame(CYC_W'(6 * 10 + 3 * FLUSH));
        run_frame(10);
        repeat (3) @(negedge clk);

`ifdef SEQ_WATCHDOG_EN
        // Withheld pool_done in AVG1 trips the 100-cycle watchdog
        exp_q.push_back({4'd2, 1'b0, 1'b1, 2'd0});
        exp_q.push_back({4'd3, 1'b1, 1'b1, 2'd0});
        exp_q.push_back({4'd1, 1'b1, 1'b0, 2'd3});
        fd_q.push_back(CYC_W'(5 + 100));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step(4'd2, 5, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        wait_state(4'd1);
        chk("watchdog_err", err, 1);
        @(negedge clk);
        exp_q.push_back({4'd2, 1'b0, 1'b1, 2'd0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("watchdog_err_cleared", err, 0);
        repeat (2) @(negedge clk);
`endif

        chk("exp_q_drained", exp_q.size(), 0);
        chk("fd_q_drained", fd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
